// File: rtl/pcap_stream_pkg.sv
// Shared definitions for the byte-to-word packet stream widener:
// FSM state encoding and the lane-index width helper.
package pcap_stream_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Width of a lane index for a word of 'bytes' lanes (never below one bit).
    function automatic int lane_w(input int bytes);
        int w;
        w = $clog2(bytes);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count up on inc until the all-ones ceiling is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= {W{1'b0}};
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + {{(W-1){1'b0}}, 1'b1};
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/pcap_stream_widener.sv
// Packs a byte stream with sop/eop framing into BYTES-wide network-order words,
// flags framing errors, enforces an inter-packet gap and keeps packet statistics.
module pcap_stream_widener
    import pcap_stream_pkg::*;
#(
    parameter int BYTES = 8,
    parameter int IPG   = 12,
    parameter int CNT_W = 16
) (
    input  logic                        CLOCK,
    input  logic                        RESET_N,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    input  logic                        in_sop,
    input  logic                        in_eop,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [8*BYTES-1:0]          out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [lane_w(BYTES)-1:0]    out_empty,
    output logic                        out_err,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            pkt_count,
    output logic [CNT_W-1:0]            err_count
);

    localparam int              LW        = lane_w(BYTES);
    localparam logic [LW-1:0]   LAST_LANE = LW'(BYTES - 1);
    localparam logic [7:0]      GAP_LAST  = (IPG == 0) ? 8'd0 : 8'(IPG - 1);
    localparam logic [1:0]      ST_EOP    = (IPG == 0) ? ST_IDLE : ST_GAP;

    logic [1:0]           state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [8*BYTES-1:0]   acc_q, acc_d;
    logic                 first_q, first_d;
    logic                 sticky_q, sticky_d;
    logic [7:0]           gap_q, gap_d;

    logic                 out_valid_q, out_sop_q, out_eop_q, out_err_q;
    logic [8*BYTES-1:0]   out_data_q;
    logic [LW-1:0]        out_empty_q;
    logic [CNT_W-1:0]     pkt_count_q;

    logic                 in_ready_s, accept_s, take_s, err_inc_s, load_s;
    logic                 sop_now_s, err_now_s, w_sop_s, w_eop_s, w_err_s;
    logic [8*BYTES-1:0]   word_s;
    logic [LW-1:0]        w_empty_s;

    assign in_ready_s = (state_q != ST_GAP) && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Framing FSM, lane packing and next-word assembly.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        acc_d     = acc_q;
        first_d   = first_q;
        sticky_d  = sticky_q;
        gap_d     = gap_q;
        take_s    = 1'b0;
        err_inc_s = 1'b0;
        load_s    = 1'b0;
        word_s    = acc_q;
        w_sop_s   = 1'b0;
        w_eop_s   = 1'b0;
        w_err_s   = 1'b0;
        w_empty_s = {LW{1'b0}};
        sop_now_s = (state_q == ST_IDLE) || first_q;
        err_now_s = sticky_q || ((state_q == ST_FILL) && in_sop);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    take_s    = in_sop;
                    err_inc_s = !in_sop;
                end else begin
                    take_s    = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    take_s    = 1'b1;
                    err_inc_s = in_sop;
                end else begin
                    take_s    = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = 8'd0;
                end else begin
                    gap_d   = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_q == LW'(i)) begin
                    word_s[8*(BYTES-1-i) +: 8] = in_data;
                end else begin
                    word_s[8*(BYTES-1-i) +: 8] = acc_q[8*(BYTES-1-i) +: 8];
                end
            end
            if (in_eop || (lane_q == LAST_LANE)) begin
                load_s    = 1'b1;
                w_sop_s   = sop_now_s;
                w_eop_s   = in_eop;
                w_err_s   = in_eop && err_now_s;
                w_empty_s = in_eop ? (LAST_LANE - lane_q) : {LW{1'b0}};
                lane_d    = {LW{1'b0}};
                acc_d     = {(8*BYTES){1'b0}};
                first_d   = 1'b0;
            end else begin
                lane_d    = lane_q + {{(LW-1){1'b0}}, 1'b1};
                acc_d     = word_s;
                first_d   = sop_now_s;
            end
            // The sticky error belongs to the packet, so it is dropped at its end.
            if (in_eop) begin
                sticky_d = 1'b0;
                state_d  = ST_EOP;
                gap_d    = 8'd0;
            end else begin
                sticky_d = err_now_s;
                state_d  = ST_FILL;
            end
        end else begin
            word_s = acc_q;
        end
    end

    // Framing state and partial-word storage.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            lane_q   <= {LW{1'b0}};
            acc_q    <= {(8*BYTES){1'b0}};
            first_q  <= 1'b0;
            sticky_q <= 1'b0;
            gap_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            acc_q    <= acc_d;
            first_q  <= first_d;
            sticky_q <= sticky_d;
            gap_q    <= gap_d;
        end
    end

    // Output word register: loads only when the previous word is gone or leaving.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {(8*BYTES){1'b0}};
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_empty_q <= {LW{1'b0}};
        end else if (load_s) begin
            out_valid_q <= 1'b1;
            out_data_q  <= word_s;
            out_sop_q   <= w_sop_s;
            out_eop_q   <= w_eop_s;
            out_err_q   <= w_err_s;
            out_empty_q <= w_empty_s;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    // Delivered-packet counter, wraps naturally.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pkt_count_q <= {CNT_W{1'b0}};
        end else if (out_valid_q && out_ready && out_eop_q) begin
            pkt_count_q <= pkt_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pkt_count_q <= pkt_count_q;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .inc   (err_inc_s),
        .value (err_count)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_err   = out_err_q;
    assign out_empty = out_empty_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pcap_stream_widener.sv
// Scoreboard bench for pcap_stream_widener with BYTES=4, IPG=2.
module tb_pcap_stream_widener;

    localparam int BYTES = 4;
    localparam int IPG   = 2;
    localparam int CNT_W = 16;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop, out_eop, out_err;
    logic [1:0]  out_empty;
    logic        out_ready = 1'b1;
    logic [15:0] pkt_count, err_count;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  emp;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e_w;
    int   n_vec = 0;
    int   n_err = 0;

    pcap_stream_widener #(.BYTES(BYTES), .IPG(IPG), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_err(out_err), .out_ready(out_ready),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        bit ok;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge CLOCK);
            if (in_ready) ok = 1'b1;
            @(posedge CLOCK);
            #1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] emp, input logic err);
        exp_t x;
        x.d = d; x.s = s; x.e = e; x.emp = emp; x.err = err;
        sb.push_back(x);
    endtask

    // Compare every output handshake against the oldest expected word.
    always @(negedge CLOCK) begin
        if (RESET_N && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {32'd0, out_data}, 64'd0);
            end else begin
                e_w = sb.pop_front();
                check("out_data",  {32'd0, out_data}, {32'd0, e_w.d});
                check("out_sop",   {63'd0, out_sop},  {63'd0, e_w.s});
                check("out_eop",   {63'd0, out_eop},  {63'd0, e_w.e});
                check("out_empty", {62'd0, out_empty}, {62'd0, e_w.emp});
                check("out_err",   {63'd0, out_err},  {63'd0, e_w.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  {32'd0, out_data}, 64'd0);
        check("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        RESET_N = 1'b1;
        check("ready_after_rst", {63'd0, in_ready}, 64'd1);
        idle(1);

        // Six-byte packet split over two words, then the gap
        push(32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h05060000, 1'b0, 1'b1, 2'd2, 1'b0);
        for (int i = 1; i <= 6; i++) send(8'(i), i == 1, i == 6);
        check("gap_ready_c1", {63'd0, in_ready}, 64'd0);
        idle(1);
        check("gap_ready_c2", {63'd0, in_ready}, 64'd0);
        idle(1);
        check("gap_ready_end", {63'd0, in_ready}, 64'd1);
        idle(2);
        check("pkt_count_1", {48'd0, pkt_count}, 64'd1);

        // Single-byte packet
        push(32'hAA000000, 1'b1, 1'b1, 2'd3, 1'b0);
        send(8'hAA, 1'b1, 1'b1);
        idle(4);
        check("pkt_count_2", {48'd0, pkt_count}, 64'd2);
        check("err_count_0", {48'd0, err_count}, 64'd0);

        // Backpressure with a full word pending
        push(32'h20212223, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h24252627, 1'b0, 1'b1, 2'd0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), i == 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("stall_in_ready",  {63'd0, in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_out_data",  {32'd0, out_data}, 64'h20212223);
            idle(1);
        end
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(8'h20 + 8'(i), 1'b0, i == 7);
        idle(4);
        check("pkt_count_3", {48'd0, pkt_count}, 64'd3);

        // Bytes without sop while idle are dropped
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        idle(3);
        check("drop_err_count", {48'd0, err_count}, 64'd2);
        check("drop_no_output", {32'd0, sb.size()}, 64'd0);
        push(32'h31323334, 1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 1; i <= 4; i++) send(8'h30 + 8'(i), i == 1, i == 4);
        idle(4);
        check("pkt_count_4", {48'd0, pkt_count}, 64'd4);

        // Stray sop inside a packet
        push(32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h05000000, 1'b0, 1'b1, 2'd3, 1'b1);
        for (int i = 1; i <= 5; i++) send(8'(i), (i == 1) || (i == 3), i == 5);
        idle(4);
        check("sop_err_count", {48'd0, err_count}, 64'd3);
        check("pkt_count_5",   {48'd0, pkt_count}, 64'd5);

        // Reset in the middle of a packet
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_pkt_count", {48'd0, pkt_count}, 64'd0);
        check("mid_rst_err_count", {48'd0, err_count}, 64'd0);
        idle(2);
        RESET_N = 1'b1;
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        push(32'h0A0B0C0D, 1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) send(8'h0A + 8'(i), i == 0, i == 3);
        idle(4);
        check("post_rst_pkt_count", {48'd0, pkt_count}, 64'd1);
        check("sb_drained", {32'd0, sb.size()}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcap_stream_widener.md
PCAP_STREAM_WIDENER -- requirements
Module: pcap_stream_widener

Interface
REQ-001 SHALL have parameter BYTES, default 8; output lanes per word; power of two, 2..64.
REQ-002 SHALL have parameter IPG, default 12; idle cycles forced after each packet's last word; 0..255.
REQ-003 SHALL have parameter CNT_W, default 16; width of the statistics counters.
REQ-004 SHALL have port CLOCK  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  byte present.
REQ-007 SHALL have port in_data  in  8  packet byte.
REQ-008 SHALL have port in_sop  in  1  byte is first of its packet.
REQ-009 SHALL have port in_eop  in  1  byte is last of its packet.
REQ-010 SHALL have port in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-011 SHALL have port out_valid  out  1  word present.
REQ-012 SHALL have port out_data  out  8*BYTES  word; first byte in bits [8*BYTES-1 -: 8] (network order).
REQ-013 SHALL have port out_sop / out_eop  out  1 each  first / last word of packet.
REQ-014 SHALL have port out_empty  out  clog2(BYTES)  unused low lanes in eop word; 0 otherwise.
REQ-015 SHALL have port out_err  out  1  packet had a framing error; valid with out_eop.
REQ-016 SHALL have port out_ready  in  1  word consumed when out_valid && out_ready.
REQ-017 SHALL have port pkt_count  out  CNT_W  packets delivered; wraps.
REQ-018 SHALL have port err_count  out  CNT_W  framing errors; saturates at all-ones.

Function
REQ-019 SHALL implement FSM IDLE, FILL, GAP; IDLE->FILL on accepted in_sop byte without in_eop; IDLE/FILL->GAP on accepted in_eop byte; GAP->IDLE after IPG cycles; IPG=0 returns to IDLE directly.
REQ-020 in_ready SHALL equal (state != GAP) && (!out_valid || out_ready).
REQ-021 Accepted bytes SHALL fill lanes from the top; lane index resets at packet start and after each emitted word.
REQ-022 A byte filling the last lane or carrying in_eop SHALL load the output register in the same edge; out_valid rises next cycle (latency 1 from final byte).
REQ-023 Unused lanes of an eop word SHALL be zero; out_empty = BYTES - bytes in word.
REQ-024 out_data/out_sop/out_eop/out_empty/out_err SHALL stay stable while out_valid && !out_ready.
REQ-025 in_sop && in_eop on one byte SHALL yield a single word with out_sop=out_eop=1, out_empty=BYTES-1.
REQ-026 A byte arriving in IDLE without in_sop SHALL be dropped, with err_count incremented.
REQ-027 in_sop in FILL SHALL be treated as data, set the packet's sticky error, and increment err_count; the packet's eop word carries out_err=1.
REQ-028 The GAP counter SHALL start the cycle after the eop byte is accepted; in_ready=0 throughout GAP; the output handshake continues during GAP.
REQ-029 pkt_count SHALL increment on each eop word handshake; CNT_W all-ones wraps to 0.
REQ-030 err_count and pkt_count events in the same cycle SHALL both apply.

Reset
REQ-031 RESET_N low SHALL immediately set state IDLE, lane 0, out_valid 0, out_data 0, out_sop/eop/err 0, out_empty 0, counters 0, sticky error 0.
REQ-032 Reset mid-packet SHALL discard partial and pending words; the first post-reset packet SHALL start in lane 0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 Package pcap_stream_pkg SHALL hold the state encoding and the lane-index width function.
REQ-035 Saturating err_count SHALL be a sub-module sat_counter (parameter W, inc, value); other logic stays flat.

Verification (BYTES=4, IPG=2)
REQ-036 6-byte packet 01..06, out_ready=1 -> words 01020304 (sop), 05060000 (eop, empty=2); pkt_count=1; in_ready low 2 cycles.
REQ-037 Single byte AA with sop+eop -> AA000000, sop=eop=1, empty=3, err=0.
REQ-038 out_ready=0 for 5 cycles with a word pending -> in_ready=0, out_data unchanged; stream resumes without loss.
REQ-039 Bytes 11, 22 without sop in IDLE -> no output, err_count=2; next valid packet unaffected.
REQ-040 Packet 01..05 with sop also on byte 03 -> 01020304, 05000000 (eop, err=1); err_count=1.
REQ-041 RESET_N low after 2 bytes of a packet -> out_valid 0, counters 0; next packet 0A..0D -> 0A0B0C0D, sop=eop=1, empty=0.
